seven_seg_capture: RTL and testbench

- Decodes a time-multiplexed, active-low seven-segment bus back into hex nibbles.
- This is the inverse of the team's hex-to-segment encoding, used to check or read back display traffic on the wall-clock board.
- A (digit-select, segment) pair is committed only after it has been stable for a programmable dwell.
- The block assembles a NUM_DIGITS-wide value and flags invalid patterns, bad selects and completed frames.

---
 rtl/seven_seg_capture_pkg.sv | 30 +++
 rtl/seven_seg_pattern_decoder.sv | 37 +++
 rtl/seven_seg_capture.sv | 150 +++++++++++++++
 tb/tb_seven_seg_capture.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_capture_pkg.sv
// Shared seven-segment constants (active-low, bit0=a .. bit6=g) and capture FSM states.
// The encoder uses the same pattern table, so the two stay in lockstep.
package seven_seg_capture_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_HEX_0 = 7'h40;
   localparam logic [6:0] SEG_HEX_1 = 7'h79;
   localparam logic [6:0] SEG_HEX_2 = 7'h24;
   localparam logic [6:0] SEG_HEX_3 = 7'h30;
   localparam logic [6:0] SEG_HEX_4 = 7'h19;
   localparam logic [6:0] SEG_HEX_5 = 7'h12;
   localparam logic [6:0] SEG_HEX_6 = 7'h02;
   localparam logic [6:0] SEG_HEX_7 = 7'h78;
   localparam logic [6:0] SEG_HEX_8 = 7'h00;
   localparam logic [6:0] SEG_HEX_9 = 7'h18;
   localparam logic [6:0] SEG_HEX_A = 7'h08;
   localparam logic [6:0] SEG_HEX_B = 7'h03;
   localparam logic [6:0] SEG_HEX_C = 7'h46;
   localparam logic [6:0] SEG_HEX_D = 7'h21;
   localparam logic [6:0] SEG_HEX_E = 7'h06;
   localparam logic [6:0] SEG_HEX_F = 7'h0E;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } capture_state_t;

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// Combinational inverse of the hex-to-segment encoder: pattern -> nibble, legal and blank flags.
module seven_seg_pattern_decoder
   import seven_seg_capture_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_nibble,
   output logic       o_isLegal,
   output logic       o_isBlank
);

   always_comb begin
      o_nibble  = '0;
      o_isLegal = 1'b1;
      case (i_seg)
         SEG_HEX_0: o_nibble = 4'h0;
         SEG_HEX_1: o_nibble = 4'h1;
         SEG_HEX_2: o_nibble = 4'h2;
         SEG_HEX_3: o_nibble = 4'h3;
         SEG_HEX_4: o_nibble = 4'h4;
         SEG_HEX_5: o_nibble = 4'h5;
         SEG_HEX_6: o_nibble = 4'h6;
         SEG_HEX_7: o_nibble = 4'h7;
         SEG_HEX_8: o_nibble = 4'h8;
         SEG_HEX_9: o_nibble = 4'h9;
         SEG_HEX_A: o_nibble = 4'hA;
         SEG_HEX_B: o_nibble = 4'hB;
         SEG_HEX_C: o_nibble = 4'hC;
         SEG_HEX_D: o_nibble = 4'hD;
         SEG_HEX_E: o_nibble = 4'hE;
         SEG_HEX_F: o_nibble = 4'hF;
         default:   o_isLegal = 1'b0;
      endcase
   end

   assign o_isBlank = (i_seg == SEG_BLANK);

endmodule

// File: rtl/seven_seg_capture.sv
// Reads back a multiplexed active-low seven-segment bus: each (select, pattern) pair is
// committed once after a stable dwell, building per-digit nibbles plus frame/error pulses.
module seven_seg_capture
   import seven_seg_capture_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 4
)(
   input  logic                    clock,
   input  logic                    resetn,
   input  logic [6:0]              segIn,
   input  logic [NUM_DIGITS-1:0]   digitSel,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   digitValid,
   output logic                    frameValid,
   output logic                    patternError,
   output logic                    selError
);

   localparam int unsigned      CNT_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(STABLE_CYCLES);

   capture_state_t              r_state;
   capture_state_t              w_stateNext;
   logic [CNT_W-1:0]            r_stableCnt;
   logic [CNT_W-1:0]            w_stableCntNext;
   logic [6:0]                  r_prevSeg;
   logic [NUM_DIGITS-1:0]       r_prevSel;
   logic                        w_match;
   logic                        w_commit;
   logic                        w_multiSel;
   logic                        w_anySel;
   logic [NUM_DIGITS-1:0]       w_seenNext;

   logic [4*NUM_DIGITS-1:0]     r_value;
   logic [NUM_DIGITS-1:0]       r_digitValid;
   logic [NUM_DIGITS-1:0]       r_seenMask;
   logic                        r_frameValid;
   logic                        r_patternError;
   logic                        r_selError;

   logic [3:0]                  w_nibble;
   logic                        w_isLegal;
   logic                        w_isBlank;

   seven_seg_pattern_decoder u_decoder (
      .i_seg     (segIn),
      .o_nibble  (w_nibble),
      .o_isLegal (w_isLegal),
      .o_isBlank (w_isBlank)
   );

   assign w_match    = (segIn == r_prevSeg) && (digitSel == r_prevSel);
   assign w_anySel   = |digitSel;
   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign w_multiSel = |(digitSel & (digitSel - NUM_DIGITS'(1)));
   assign w_seenNext = r_seenMask | digitSel;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_stableCnt <= '0;
         r_prevSeg   <= '0;
         r_prevSel   <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_stableCnt <= w_stableCntNext;
         r_prevSeg   <= segIn;
         r_prevSel   <= digitSel;
      end
   end

   always_comb begin
      w_stateNext     = r_state;
      w_stableCntNext = r_stableCnt;
      w_commit        = 1'b0;
      case (r_state)
         IDLE: begin
            w_stateNext     = SETTLE;
            w_stableCntNext = CNT_ONE;
         end
         SETTLE: begin
            if (!w_match) begin
               w_stableCntNext = CNT_ONE;
            end else if (r_stableCnt >= CNT_COMMIT) begin
               w_commit        = 1'b1;
               w_stateNext     = HELD;
               w_stableCntNext = CNT_FULL;
            end else begin
               w_stableCntNext = r_stableCnt + CNT_ONE;
            end
         end
         HELD: begin
            if (!w_match) begin
               w_stateNext     = SETTLE;
               w_stableCntNext = CNT_ONE;
            end
         end
         default: begin
            w_stateNext     = IDLE;
            w_stableCntNext = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_value        <= '0;
         r_digitValid   <= '0;
         r_seenMask     <= '0;
         r_frameValid   <= 1'b0;
         r_patternError <= 1'b0;
         r_selError     <= 1'b0;
      end else begin
         r_frameValid   <= 1'b0;
         r_patternError <= 1'b0;
         r_selError     <= 1'b0;
         if (w_commit) begin
            if (w_multiSel) begin
               r_selError <= 1'b1;
            end else if (w_anySel) begin
               for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                  if (digitSel[i]) begin
                     if (w_isLegal) begin
                        r_value[4*i +: 4] <= w_nibble;
                     end
                     r_digitValid[i] <= w_isLegal;
                  end
               end
               r_patternError <= !w_isLegal && !w_isBlank;
               if (&w_seenNext) begin
                  r_frameValid <= 1'b1;
                  r_seenMask   <= '0;
               end else begin
                  r_seenMask   <= w_seenNext;
               end
            end
         end
      end
   end

   assign value        = r_value;
   assign digitValid   = r_digitValid;
   assign frameValid   = r_frameValid;
   assign patternError = r_patternError;
   assign selError     = r_selError;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: each scenario queues the outputs it expects at
// given cycles and compares them when the run reaches those cycles.
module tb_seven_seg_capture;

   typedef struct {
      int unsigned cyc;
      logic [15:0] val;
      logic [3:0]  dv;
      logic        fv;
      logic        pe;
      logic        se;
   } exp_t;

   logic        clock = 1'b0;
   logic        resetn;
   logic [6:0]  segIn;
   logic [3:0]  digitSel;
   logic [15:0] value;
   logic [3:0]  digitValid;
   logic        frameValid;
   logic        patternError;
   logic        selError;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          fv_cnt, pe_cnt, se_cnt;

   seven_seg_capture #(
      .NUM_DIGITS    (4),
      .STABLE_CYCLES (4)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .segIn        (segIn),
      .digitSel     (digitSel),
      .value        (value),
      .digitValid   (digitValid),
      .frameValid   (frameValid),
      .patternError (patternError),
      .selError     (selError)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time=%0t want <200000", $time);
      $fatal(1);
   end

   task automatic step(input logic [3:0] sel, input logic [6:0] seg);
      digitSel = sel;
      segIn    = seg;
      @(posedge clock);
      #1;
      cyc++;
      if (frameValid)   fv_cnt++;
      if (patternError) pe_cnt++;
      if (selError)     se_cnt++;
   endtask

   task automatic clear_counts();
      fv_cnt = 0;
      pe_cnt = 0;
      se_cnt = 0;
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      segIn    = 7'h00;
      digitSel = 4'h0;
      repeat (2) @(posedge clock);
      #1;
      n_tests++;
      if ({value, digitValid, frameValid, patternError, selError} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_state: got val=%h dv=%b fv=%b pe=%b se=%b want all zero",
                  value, digitValid, frameValid, patternError, selError);
      end
      resetn = 1'b1;
   endtask

   task automatic test_single_digit();
      exp_t        e;
      int unsigned c0 = cyc;
      clear_counts();
      sb.push_back('{c0 + 3,  16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 4,  16'h0003, 4'b0001, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 14, 16'h0003, 4'b0001, 1'b0, 1'b0, 1'b0});
      for (int n = 0; n < 14; n++) begin
         step(4'b0001, 7'h30);
         if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_tests++;
            if ({value, digitValid, frameValid, patternError, selError} !== {e.val, e.dv, e.fv, e.pe, e.se}) begin
               n_fail++;
               $display("FAIL single@%0d: got val=%h dv=%b fv=%b pe=%b se=%b want val=%h dv=%b fv=%b pe=%b se=%b",
                        cyc - c0, value, digitValid, frameValid, patternError, selError, e.val, e.dv, e.fv, e.pe, e.se);
            end
         end
      end
      n_tests++;
      if (fv_cnt != 0 || pe_cnt != 0 || se_cnt != 0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL single_pulses: got fv=%0d pe=%0d se=%0d pending=%0d want 0 0 0 0",
                  fv_cnt, pe_cnt, se_cnt, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_frame();
      exp_t        e;
      int unsigned c0 = cyc;
      logic [3:0]  sels [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
      logic [6:0]  segs [8] = '{7'h00,   7'h79,   7'h00,   7'h24,   7'h00,   7'h19,   7'h00,   7'h0E};
      int          lens [8] = '{1, 4, 1, 4, 1, 4, 1, 5};
      clear_counts();
      sb.push_back('{c0 + 5,  16'h0001, 4'b0001, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 10, 16'h0021, 4'b0011, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 15, 16'h0421, 4'b0111, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 19, 16'h0421, 4'b0111, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 20, 16'hF421, 4'b1111, 1'b1, 1'b0, 1'b0});
      sb.push_back('{c0 + 21, 16'hF421, 4'b1111, 1'b0, 1'b0, 1'b0});
      for (int r = 0; r < 8; r++) begin
         for (int n = 0; n < lens[r]; n++) begin
            step(sels[r], segs[r]);
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
               e = sb.pop_front();
               n_tests++;
               if ({value, digitValid, frameValid, patternError, selError} !== {e.val, e.dv, e.fv, e.pe, e.se}) begin
                  n_fail++;
                  $display("FAIL frame@%0d: got val=%h dv=%b fv=%b pe=%b se=%b want val=%h dv=%b fv=%b pe=%b se=%b",
                           cyc - c0, value, digitValid, frameValid, patternError, selError, e.val, e.dv, e.fv, e.pe, e.se);
               end
            end
         end
      end
      n_tests++;
      if (fv_cnt != 1 || pe_cnt != 0 || se_cnt != 0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL frame_pulses: got fv=%0d pe=%0d se=%0d pending=%0d want 1 0 0 0",
                  fv_cnt, pe_cnt, se_cnt, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_blank_invalid();
      exp_t        e;
      int unsigned c0 = cyc;
      logic [6:0]  segs [2] = '{7'h7F, 7'h55};
      int          lens [2] = '{4, 5};
      clear_counts();
      sb.push_back('{c0 + 4, 16'hF421, 4'b1101, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 8, 16'hF421, 4'b1101, 1'b0, 1'b1, 1'b0});
      sb.push_back('{c0 + 9, 16'hF421, 4'b1101, 1'b0, 1'b0, 1'b0});
      for (int r = 0; r < 2; r++) begin
         for (int n = 0; n < lens[r]; n++) begin
            step(4'b0010, segs[r]);
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
               e = sb.pop_front();
               n_tests++;
               if ({value, digitValid, frameValid, patternError, selError} !== {e.val, e.dv, e.fv, e.pe, e.se}) begin
                  n_fail++;
                  $display("FAIL blank_invalid@%0d: got val=%h dv=%b fv=%b pe=%b se=%b want val=%h dv=%b fv=%b pe=%b se=%b",
                           cyc - c0, value, digitValid, frameValid, patternError, selError, e.val, e.dv, e.fv, e.pe, e.se);
               end
            end
         end
      end
      n_tests++;
      if (fv_cnt != 0 || pe_cnt != 1 || se_cnt != 0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL blank_invalid_pulses: got fv=%0d pe=%0d se=%0d pending=%0d want 0 1 0 0",
                  fv_cnt, pe_cnt, se_cnt, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_unstable();
      exp_t        e;
      int unsigned c0;
      resetn = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      c0 = cyc;
      clear_counts();
      sb.push_back('{c0 + 12, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 24, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0});
      for (int r = 0; r < 8; r++) begin
         for (int n = 0; n < 3; n++) begin
            step(4'b0001, (r % 2 == 0) ? 7'h40 : 7'h79);
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
               e = sb.pop_front();
               n_tests++;
               if ({value, digitValid, frameValid, patternError, selError} !== {e.val, e.dv, e.fv, e.pe, e.se}) begin
                  n_fail++;
                  $display("FAIL unstable@%0d: got val=%h dv=%b fv=%b pe=%b se=%b want val=%h dv=%b fv=%b pe=%b se=%b",
                           cyc - c0, value, digitValid, frameValid, patternError, selError, e.val, e.dv, e.fv, e.pe, e.se);
               end
            end
         end
      end
      n_tests++;
      if (fv_cnt != 0 || pe_cnt != 0 || se_cnt != 0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL unstable_pulses: got fv=%0d pe=%0d se=%0d pending=%0d want 0 0 0 0",
                  fv_cnt, pe_cnt, se_cnt, sb.size());
         sb.delete();
      end
   endtask

   // Multi-hot select must not mark digits seen: the frame completes only once digit 1 really commits.
   task automatic test_sel_error();
      exp_t        e;
      int unsigned c0 = cyc;
      logic [3:0]  sels [5] = '{4'b0001, 4'b0011, 4'b0100, 4'b1000, 4'b0010};
      logic [6:0]  segs [5] = '{7'h40,   7'h79,   7'h24,   7'h30,   7'h19};
      clear_counts();
      sb.push_back('{c0 + 4,  16'h0000, 4'b0001, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 8,  16'h0000, 4'b0001, 1'b0, 1'b0, 1'b1});
      sb.push_back('{c0 + 12, 16'h0200, 4'b0101, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 16, 16'h3200, 4'b1101, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 20, 16'h3240, 4'b1111, 1'b1, 1'b0, 1'b0});
      for (int r = 0; r < 5; r++) begin
         for (int n = 0; n < 4; n++) begin
            step(sels[r], segs[r]);
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
               e = sb.pop_front();
               n_tests++;
               if ({value, digitValid, frameValid, patternError, selError} !== {e.val, e.dv, e.fv, e.pe, e.se}) begin
                  n_fail++;
                  $display("FAIL sel_error@%0d: got val=%h dv=%b fv=%b pe=%b se=%b want val=%h dv=%b fv=%b pe=%b se=%b",
                           cyc - c0, value, digitValid, frameValid, patternError, selError, e.val, e.dv, e.fv, e.pe, e.se);
               end
            end
         end
      end
      n_tests++;
      if (fv_cnt != 1 || pe_cnt != 0 || se_cnt != 1 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL sel_error_pulses: got fv=%0d pe=%0d se=%0d pending=%0d want 1 0 1 0",
                  fv_cnt, pe_cnt, se_cnt, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset_mid_dwell();
      exp_t        e;
      int unsigned c0;
      step(4'b0100, 7'h00);
      step(4'b0100, 7'h00);
      #2 resetn = 1'b0;
      #1;
      n_tests++;
      if ({value, digitValid, frameValid, patternError, selError} !== 23'd0) begin
         n_fail++;
         $display("FAIL mid_reset_async: got val=%h dv=%b fv=%b pe=%b se=%b want all zero",
                  value, digitValid, frameValid, patternError, selError);
      end
      repeat (2) @(posedge clock);
      #1;
      n_tests++;
      if ({value, digitValid, frameValid, patternError, selError} !== 23'd0) begin
         n_fail++;
         $display("FAIL mid_reset_held: got val=%h dv=%b fv=%b pe=%b se=%b want all zero",
                  value, digitValid, frameValid, patternError, selError);
      end
      resetn = 1'b1;
      c0 = cyc;
      clear_counts();
      sb.push_back('{c0 + 3, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 4, 16'h0800, 4'b0100, 1'b0, 1'b0, 1'b0});
      sb.push_back('{c0 + 5, 16'h0800, 4'b0100, 1'b0, 1'b0, 1'b0});
      for (int n = 0; n < 5; n++) begin
         step(4'b0100, 7'h00);
         if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_tests++;
            if ({value, digitValid, frameValid, patternError, selError} !== {e.val, e.dv, e.fv, e.pe, e.se}) begin
               n_fail++;
               $display("FAIL mid_reset@%0d: got val=%h dv=%b fv=%b pe=%b se=%b want val=%h dv=%b fv=%b pe=%b se=%b",
                        cyc - c0, value, digitValid, frameValid, patternError, selError, e.val, e.dv, e.fv, e.pe, e.se);
            end
         end
      end
      n_tests++;
      if (fv_cnt != 0 || pe_cnt != 0 || se_cnt != 0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL mid_reset_pulses: got fv=%0d pe=%0d se=%0d pending=%0d want 0 0 0 0",
                  fv_cnt, pe_cnt, se_cnt, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_single_digit();
      test_frame();
      test_blank_invalid();
      test_unstable();
      test_sel_error();
      test_reset_mid_dwell();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
